// File: rtl/nx_token_scheduler.sv
// Per-tick token scheduler: grants mesh column tokens in ascending index order,
// bounds the number of tokens in flight, and signals completion once every token is back.
module nx_token_scheduler #(
   parameter int unsigned COLUMNS    = 3,
   parameter int unsigned MAX_ACTIVE = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               trigger_i,
   input  logic [COLUMNS-1:0] mask_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [COLUMNS-1:0] token_grant_o,
   input  logic [COLUMNS-1:0] token_release_i,
   output logic [31:0]        ticks_o,
   output logic               error_o
);

   localparam int unsigned CW = $clog2(COLUMNS + 1);

   typedef enum logic [1:0] {IDLE, GRANT, WAIT, DONE} state_t;

   state_t             state, state_nx;
   logic [COLUMNS-1:0] pending, pending_nx;
   logic [COLUMNS-1:0] outstanding, outstanding_nx;
   logic [COLUMNS-1:0] grant_nx;
   logic [COLUMNS-1:0] pend_eff;
   logic [CW-1:0]      count;
   logic               accept;
   logic               can_grant;
   logic               error_nx;

   function automatic logic [CW-1:0] popcount(input logic [COLUMNS-1:0] v);
      logic [CW-1:0] n;
      n = '0;
      for (int unsigned i = 0; i < COLUMNS; i++) begin
         n = n + CW'(v[i]);
      end
      return n;
   endfunction

   // Slot occupancy comes from the registered outstanding set, so a release frees its slot a cycle later.
   assign count = popcount(outstanding);

   // Next-state, grant selection and release bookkeeping
   always_comb begin
      state_nx       = state;
      error_nx       = error_o;
      accept         = trigger_i && ((state == IDLE) || (state == DONE));
      pend_eff       = accept ? mask_i : pending;
      can_grant      = (accept || (state == GRANT)) && (32'(count) < MAX_ACTIVE) && (pend_eff != '0);
      grant_nx       = can_grant ? (pend_eff & (~pend_eff + COLUMNS'(1))) : '0;
      pending_nx     = pend_eff & ~grant_nx;
      outstanding_nx = (outstanding & ~token_release_i) | grant_nx;

      if ((token_release_i & ~outstanding) != '0) begin
         error_nx = 1'b1;
      end
      if (trigger_i && ((state == GRANT) || (state == WAIT))) begin
         error_nx = 1'b1;
      end

      case (state)
         IDLE, DONE: begin
            if (accept) begin
               state_nx = (mask_i != '0) ? GRANT : DONE;
            end else begin
               state_nx = IDLE;
            end
         end
         GRANT: begin
            if (pending_nx == '0) begin
               state_nx = (outstanding_nx == '0) ? DONE : WAIT;
            end
         end
         WAIT: begin
            if (outstanding_nx == '0) begin
               state_nx = DONE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State and registered outputs; decoding from state_nx keeps busy/done aligned with the state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state         <= IDLE;
         pending       <= '0;
         outstanding   <= '0;
         token_grant_o <= '0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         ticks_o       <= '0;
         error_o       <= 1'b0;
      end else begin
         state         <= state_nx;
         pending       <= pending_nx;
         outstanding   <= outstanding_nx;
         token_grant_o <= grant_nx;
         busy_o        <= (state_nx == GRANT) || (state_nx == WAIT);
         done_o        <= (state_nx == DONE);
         error_o       <= error_nx;
         if (state_nx == DONE) begin
            ticks_o <= ticks_o + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_nx_token_scheduler.sv
// Directed bench for nx_token_scheduler: a vector table on a single-slot instance,
// plus hand sequences on a three-slot instance for parallel grants, async reset and wrap.
module tb_nx_token_scheduler;

   localparam int unsigned COLUMNS = 3;

   logic               clk = 1'b0;
   logic               rst;
   logic               trigger;
   logic [COLUMNS-1:0] mask;
   logic [COLUMNS-1:0] rel;

   logic               a_busy, a_done, a_err;
   logic [COLUMNS-1:0] a_grant;
   logic [31:0]        a_ticks;
   logic               b_busy, b_done, b_err;
   logic [COLUMNS-1:0] b_grant;
   logic [31:0]        b_ticks;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   nx_token_scheduler #(.COLUMNS(COLUMNS), .MAX_ACTIVE(1)) dut_a (
      .clk_i(clk), .rst_i(rst), .trigger_i(trigger), .mask_i(mask),
      .busy_o(a_busy), .done_o(a_done), .token_grant_o(a_grant),
      .token_release_i(rel), .ticks_o(a_ticks), .error_o(a_err)
   );

   nx_token_scheduler #(.COLUMNS(COLUMNS), .MAX_ACTIVE(3)) dut_b (
      .clk_i(clk), .rst_i(rst), .trigger_i(trigger), .mask_i(mask),
      .busy_o(b_busy), .done_o(b_done), .token_grant_o(b_grant),
      .token_release_i(rel), .ticks_o(b_ticks), .error_o(b_err)
   );

   typedef struct {
      logic        trig;
      logic [2:0]  mask;
      logic [2:0]  rel;
      logic [2:0]  grant;
      logic        busy;
      logic        done;
      logic [31:0] ticks;
      logic        err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic t, input logic [2:0] m, input logic [2:0] r,
                               input logic [2:0] g, input logic b, input logic d,
                               input logic [31:0] tk, input logic e);
      vec_t v;
      v.trig = t; v.mask = m; v.rel = r; v.grant = g;
      v.busy = b; v.done = d; v.ticks = tk; v.err = e;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      // Single slot, mask 111, each release two cycles after its grant
      vecs.push_back(mk(1, 3'b111, 3'b000, 3'b001, 1, 0, 0, 0));
      vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 1, 0, 0, 0));
      vecs.push_back(mk(0, 3'b000, 3'b001, 3'b000, 1, 0, 0, 0));
      vecs.push_back(mk(0, 3'b000, 3'b000, 3'b010, 1, 0, 0, 0));
      vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 1, 0, 0, 0));
      vecs.push_back(mk(0, 3'b000, 3'b010, 3'b000, 1, 0, 0, 0));
      vecs.push_back(mk(0, 3'b000, 3'b000, 3'b100, 1, 0, 0, 0));
      vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 1, 0, 0, 0));
      vecs.push_back(mk(0, 3'b000, 3'b100, 3'b000, 0, 1, 1, 0));
      vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 0, 1, 0));
      // Empty mask
      vecs.push_back(mk(1, 3'b000, 3'b000, 3'b000, 0, 1, 2, 0));
      vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 0, 2, 0));
      // Back-to-back: re-trigger while in DONE
      vecs.push_back(mk(1, 3'b000, 3'b000, 3'b000, 0, 1, 3, 0));
      vecs.push_back(mk(1, 3'b010, 3'b000, 3'b010, 1, 0, 3, 0));
      vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 1, 0, 3, 0));
      vecs.push_back(mk(0, 3'b000, 3'b010, 3'b000, 0, 1, 4, 0));
      vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 0, 4, 0));
      // Trigger during WAIT is ignored and flagged
      vecs.push_back(mk(1, 3'b001, 3'b000, 3'b001, 1, 0, 4, 0));
      vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 1, 0, 4, 0));
      vecs.push_back(mk(1, 3'b111, 3'b000, 3'b000, 1, 0, 4, 1));
      vecs.push_back(mk(0, 3'b000, 3'b001, 3'b000, 0, 1, 5, 1));
      vecs.push_back(mk(0, 3'b000, 3'b010, 3'b000, 0, 0, 5, 1));

      rst = 1'b1; trigger = 1'b0; mask = '0; rel = '0;
      #1;
      chk("reset_grant", 32'(a_grant), 32'd0);
      chk("reset_busy",  32'(a_busy),  32'd0);
      chk("reset_done",  32'(a_done),  32'd0);
      chk("reset_ticks", a_ticks,      32'd0);
      chk("reset_err",   32'(a_err),   32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      for (int i = 0; i < vecs.size(); i++) begin
         trigger = vecs[i].trig;
         mask    = vecs[i].mask;
         rel     = vecs[i].rel;
         tick();
         chk($sformatf("v%0d_grant", i), 32'(a_grant), 32'(vecs[i].grant));
         chk($sformatf("v%0d_busy", i),  32'(a_busy),  32'(vecs[i].busy));
         chk($sformatf("v%0d_done", i),  32'(a_done),  32'(vecs[i].done));
         chk($sformatf("v%0d_ticks", i), a_ticks,      vecs[i].ticks);
         chk($sformatf("v%0d_err", i),   32'(a_err),   32'(vecs[i].err));
      end
      trigger = 1'b0; mask = '0; rel = '0;

      // Only reset clears error; an idle release sets it again and it sticks
      rst = 1'b1;
      #1;
      chk("rst_clears_err", 32'(a_err), 32'd0);
      chk("rst_clears_ticks", a_ticks, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("idle_err_pre", 32'(a_err), 32'd0);
      rel = 3'b010;
      tick();
      rel = '0;
      chk("idle_release_err", 32'(a_err), 32'd1);
      tick();
      tick();
      chk("err_sticky", 32'(a_err), 32'd1);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();

      // Three slots, mask 101: two consecutive grants, joint release
      trigger = 1'b1; mask = 3'b101;
      tick();
      trigger = 1'b0; mask = '0;
      chk("par_grant0", 32'(b_grant), 32'b001);
      chk("par_busy0",  32'(b_busy),  32'd1);
      tick();
      chk("par_grant1", 32'(b_grant), 32'b100);
      chk("par_busy1",  32'(b_busy),  32'd1);
      rel = 3'b101;
      tick();
      rel = '0;
      chk("par_done",   32'(b_done),  32'd1);
      chk("par_busy2",  32'(b_busy),  32'd0);
      chk("par_grant2", 32'(b_grant), 32'd0);
      chk("par_ticks",  b_ticks,      32'd1);
      tick();
      chk("par_done_pulse", 32'(b_done), 32'd0);
      chk("par_busy3",  32'(b_busy),  32'd0);
      chk("par_err",    32'(b_err),   32'd0);

      // Async reset while granting with two tokens out
      trigger = 1'b1; mask = 3'b111;
      tick();
      trigger = 1'b0; mask = '0;
      chk("ar_grant0", 32'(b_grant), 32'b001);
      tick();
      chk("ar_grant1", 32'(b_grant), 32'b010);
      chk("ar_busy",   32'(b_busy),  32'd1);
      #2 rst = 1'b1;
      #1;
      chk("ar_grant_clr", 32'(b_grant), 32'd0);
      chk("ar_busy_clr",  32'(b_busy),  32'd0);
      chk("ar_done_clr",  32'(b_done),  32'd0);
      chk("ar_ticks_clr", b_ticks,      32'd0);
      chk("ar_err_clr",   32'(b_err),   32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      rel = 3'b001;
      tick();
      rel = '0;
      chk("ar_stale_release_err", 32'(b_err), 32'd1);
      chk("ar_idle_busy", 32'(b_busy), 32'd0);

      // Tick counter wraps modulo 2^32
      force dut_b.ticks_o = 32'hFFFF_FFFF;
      #1 release dut_b.ticks_o;
      trigger = 1'b1; mask = '0;
      tick();
      trigger = 1'b0;
      chk("wrap_ticks", b_ticks, 32'd0);
      chk("wrap_done",  32'(b_done), 32'd1);

      // Release on the same edge as the grant of that column is an error
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      trigger = 1'b1; mask = 3'b001; rel = 3'b001;
      tick();
      trigger = 1'b0; mask = '0; rel = '0;
      chk("same_edge_grant", 32'(b_grant), 32'b001);
      chk("same_edge_err",   32'(b_err),   32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
